// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA framebuffer path.
//   H_ACTIVE / V_ACTIVE : visible raster size in pixels / lines
//   PIX_W               : pixel width (RGB444)
//   FB_AW               : framebuffer linear address width
//   owner_t             : which client drives the RAM port on a given edge
//   clr_state_t         : frame-clear engine state
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int PIX_W    = 12;
  localparam int FB_AW    = 19;

  typedef enum logic [1:0] {
    OWN_SCAN,
    OWN_FIFO,
    OWN_CLEAR,
    OWN_IDLE
  } owner_t;

  typedef enum logic {
    C_IDLE,
    C_RUN
  } clr_state_t;

endpackage

// File: rtl/pixel_write_fifo.sv
// ---------------------------------------------------------------------------
// pixel_write_fifo
// Small synchronous FIFO holding queued {addr, data} pixel writes.
//   Clock, Reset_n : clock, asynchronous active-low reset (empties the queue)
//   push, push_data: enqueue one word (ignored while full)
//   pop, pop_data  : dequeue the head; pop_data shows the head combinationally
//   full, empty    : occupancy flags, derived from registered pointers only
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module pixel_write_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 31
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Single-port framebuffer scheduler. Visible-region scan-out reads own the
// RAM; during blanking the queued pixel writes go first, then the frame-clear
// engine. VGA controls are delayed so they leave aligned with pix_data.
//   Clock, Reset_n              : clock, asynchronous active-low reset
//   blank_n/hSync_n/vSync_n     : controls from the VGA controller
//   nextX, nextY                : scan position to fetch
//   wr_valid/wr_ready/wr_addr/wr_data : queued pixel-write port
//   clear_start/clear_colour/clear_busy : full-frame clear control
//   ram_addr/ram_we/ram_wdata   : registered RAM port
//   ram_rdata                   : RAM read data, one cycle after ram_addr
//   pix_data, pix_*             : pixel and controls to the DAC
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int PIX_W    = vga_pkg::PIX_W,
  parameter int FB_AW    = vga_pkg::FB_AW,
  parameter int WQ_DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             blank_n,
  input  logic             hSync_n,
  input  logic             vSync_n,
  input  logic [11:0]      nextX,
  input  logic [11:0]      nextY,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             clear_start,
  input  logic [PIX_W-1:0] clear_colour,
  output logic             clear_busy,
  output logic [FB_AW-1:0] ram_addr,
  output logic             ram_we,
  output logic [PIX_W-1:0] ram_wdata,
  input  logic [PIX_W-1:0] ram_rdata,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_blank_n,
  output logic             pix_hSync_n,
  output logic             pix_vSync_n
);

  import vga_pkg::*;

  localparam int                TOTAL     = H_ACTIVE * V_ACTIVE;
  localparam logic [FB_AW:0]    TOTAL_X   = (FB_AW+1)'(TOTAL);
  localparam logic [FB_AW-1:0]  LAST_ADDR = FB_AW'(TOTAL - 1);
  localparam int                WQ_W      = FB_AW + PIX_W;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [WQ_W-1:0]   fifo_head;
  logic [FB_AW-1:0]  head_addr;
  logic [PIX_W-1:0]  head_data;
  logic              head_in_range;
  logic [FB_AW-1:0]  scan_addr;
  owner_t            owner;
  clr_state_t        clr_state;
  logic [FB_AW-1:0]  clr_addr;
  logic [PIX_W-1:0]  clr_colour;
  logic [2:0]        ctl_p0;
  logic [2:0]        ctl_p1;

  // Ready comes from registered occupancy only, so a same-cycle pop never
  // makes room for a push into a full queue.
  assign wr_ready  = !fifo_full;
  assign fifo_push = wr_valid && !fifo_full;
  assign fifo_pop  = (owner == OWN_FIFO);

  pixel_write_fifo #(
    .DEPTH  (WQ_DEPTH),
    .DATA_W (WQ_W)
  ) u_wq (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .push      (fifo_push),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_addr, head_data} = fifo_head;
  // Out-of-frame writes are still popped but never reach the RAM.
  assign head_in_range = ({1'b0, head_addr} < TOTAL_X);

  // Linear scan address, deliberately computed and truncated at FB_AW width.
  assign scan_addr = FB_AW'(nextY) * FB_AW'(H_ACTIVE) + FB_AW'(nextX);

  always_comb begin
    owner = OWN_IDLE;
    if (blank_n)                 owner = OWN_SCAN;
    else if (!fifo_empty)        owner = OWN_FIFO;
    else if (clr_state == C_RUN) owner = OWN_CLEAR;
  end

  assign clear_busy = (clr_state == C_RUN);

  // Clear engine: starts only from idle, advances only on edges it owns.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_state <= C_IDLE;
      clr_addr  <= '0;
    end else begin
      case (clr_state)
        C_IDLE: begin
          if (clear_start) begin
            clr_state <= C_RUN;
            clr_addr  <= '0;
          end
        end
        default: begin
          if (owner == OWN_CLEAR) begin
            if (clr_addr == LAST_ADDR) clr_state <= C_IDLE;
            clr_addr <= clr_addr + FB_AW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (clr_state == C_IDLE && clear_start) clr_colour <= clear_colour;
  end

  // ---- stage p0: RAM port register (address valid after sampling edge) ----
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      case (owner)
        OWN_SCAN: begin
          ram_addr <= scan_addr;
          ram_we   <= 1'b0;
        end
        OWN_FIFO: begin
          if (head_in_range) begin
            ram_addr  <= head_addr;
            ram_wdata <= head_data;
            ram_we    <= 1'b1;
          end else begin
            ram_we    <= 1'b0;
          end
        end
        OWN_CLEAR: begin
          ram_addr  <= clr_addr;
          ram_wdata <= clr_colour;
          ram_we    <= 1'b1;
        end
        default: begin
          ram_we <= 1'b0;
        end
      endcase
    end
  end

  // ---- stages p0/p1: control delay matching address + RAM read latency ----
  // Bit order {blank_n, hSync_n, vSync_n}; syncs idle high.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ctl_p0 <= 3'b011;
      ctl_p1 <= 3'b011;
    end else begin
      ctl_p0 <= {blank_n, hSync_n, vSync_n};
      ctl_p1 <= ctl_p0;
    end
  end

  // ---- stage p2: DAC outputs, pixel forced to 0 while blanked ----
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_data    <= '0;
      pix_blank_n <= 1'b0;
      pix_hSync_n <= 1'b1;
      pix_vSync_n <= 1'b1;
    end else begin
      pix_data    <= ctl_p1[2] ? ram_rdata : '0;
      pix_blank_n <= ctl_p1[2];
      pix_hSync_n <= ctl_p1[1];
      pix_vSync_n <= ctl_p1[0];
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int H     = 40;
  localparam int V     = 30;
  localparam int TOTAL = H * V;
  localparam int WQ    = 4;

  logic        Clock;
  logic        Reset_n;
  logic        blank_n, hSync_n, vSync_n;
  logic [11:0] nextX, nextY;
  logic        wr_valid, wr_ready;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        clear_start;
  logic [11:0] clear_colour;
  logic        clear_busy;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata, ram_rdata, pix_data;
  logic        pix_blank_n, pix_hSync_n, pix_vSync_n;

  vga_fb_arbiter #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .PIX_W    (12),
    .FB_AW    (19),
    .WQ_DEPTH (WQ)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .blank_n      (blank_n),
    .hSync_n      (hSync_n),
    .vSync_n      (vSync_n),
    .nextX        (nextX),
    .nextY        (nextY),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .pix_data     (pix_data),
    .pix_blank_n  (pix_blank_n),
    .pix_hSync_n  (pix_hSync_n),
    .pix_vSync_n  (pix_vSync_n)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Framebuffer RAM: synchronous read, one-cycle latency.
  logic [11:0] ram [0:2047];
  always @(posedge Clock) begin
    if (ram_we) ram[ram_addr[10:0]] <= ram_wdata;
    ram_rdata <= ram[ram_addr[10:0]];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: expected RAM port, expected memory image,
  // pending write queue, clear progress and the pixel output pipeline.
  logic        m_we;
  logic [18:0] m_addr;
  logic [11:0] m_wdata;
  logic [11:0] m_mem [0:2047];
  int          qa[$];
  logic [11:0] qd[$];
  logic        m_active;
  int          m_next;
  logic [11:0] m_col;
  logic [14:0] pq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    qa.delete(); qd.delete();
    m_active = 1'b0; m_next = 0; m_col = '0;
    pq.delete();
    pq.push_back({12'h000, 3'b011});
    pq.push_back({12'h000, 3'b011});
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #2;
    check("rst_wr_ready",   32'(wr_ready),    32'd1);
    check("rst_clear_busy", 32'(clear_busy),  32'd0);
    check("rst_ram_addr",   32'(ram_addr),    32'd0);
    check("rst_ram_we",     32'(ram_we),      32'd0);
    check("rst_ram_wdata",  32'(ram_wdata),   32'd0);
    check("rst_pix_data",   32'(pix_data),    32'd0);
    check("rst_pix_blank",  32'(pix_blank_n), 32'd0);
    check("rst_pix_hsync",  32'(pix_hSync_n), 32'd1);
    check("rst_pix_vsync",  32'(pix_vSync_n), 32'd1);
    model_reset();
    #1;
    Reset_n = 1'b1;
  endtask

  // One clock: drive inputs, predict the edge from the rules, then compare.
  task automatic step(input logic b, input logic h, input logic v,
                      input int nx, input int ny,
                      input logic wv, input int wa, input logic [11:0] wd,
                      input logic cs, input logic [11:0] cc);
    logic        ready, was_active;
    logic [11:0] rd, d;
    logic [14:0] ent;
    int          a;
    blank_n = b; hSync_n = h; vSync_n = v;
    nextX = 12'(nx); nextY = 12'(ny);
    wr_valid = wv; wr_addr = 19'(wa); wr_data = wd;
    clear_start = cs; clear_colour = cc;
    // the write issued on the previous edge lands in RAM on this edge
    if (m_we) m_mem[m_addr[10:0]] = m_wdata;
    ready = (qa.size() < WQ);
    check("wr_ready", 32'(wr_ready), 32'(ready));
    was_active = m_active;
    rd = 12'h000;
    if (b) begin
      m_addr = 19'(ny * H + nx);
      m_we   = 1'b0;
      rd     = m_mem[m_addr[10:0]];
    end else if (qa.size() > 0) begin
      a = qa.pop_front();
      d = qd.pop_front();
      if (a < TOTAL) begin
        m_we = 1'b1; m_addr = 19'(a); m_wdata = d;
      end else begin
        m_we = 1'b0;
      end
    end else if (m_active) begin
      m_we = 1'b1; m_addr = 19'(m_next); m_wdata = m_col;
      m_next++;
      if (m_next == TOTAL) m_active = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (!was_active && cs) begin
      m_active = 1'b1; m_next = 0; m_col = cc;
    end
    if (wv && ready) begin
      qa.push_back(wa);
      qd.push_back(wd);
    end
    pq.push_back({b ? rd : 12'h000, b, h, v});
    @(posedge Clock);
    #1;
    check("ram_we",     32'(ram_we),     32'(m_we));
    check("ram_addr",   32'(ram_addr),   32'(m_addr));
    check("ram_wdata",  32'(ram_wdata),  32'(m_wdata));
    check("clear_busy", 32'(clear_busy), 32'(m_active));
    ent = pq.pop_front();
    check("pix_data",    32'(pix_data),    32'(ent[14:3]));
    check("pix_blank_n", 32'(pix_blank_n), 32'(ent[2]));
    check("pix_hSync_n", 32'(pix_hSync_n), 32'(ent[1]));
    check("pix_vSync_n", 32'(pix_vSync_n), 32'(ent[0]));
  endtask

  task automatic rand_visible(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'($urandom), 1'($urandom),
           int'($urandom_range(0, H-1)), int'($urandom_range(0, V-1)),
           1'b0, 0, 12'h000, 1'b0, 12'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic b;
    logic wv;
    logic cs;
    int   wa;
    logic [11:0] wd;

    Reset_n = 1'b1;
    blank_n = 1'b0; hSync_n = 1'b1; vSync_n = 1'b1;
    nextX = '0; nextY = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clear_start = 1'b0; clear_colour = '0;
    for (int i = 0; i < 2048; i++) begin
      ram[i]   = 12'(i);
      m_mem[i] = 12'(i);
    end
    model_reset();
    #1;
    do_reset();

    // visible scan: directed position, sync toggles, then random positions
    step(1'b1, 1'b0, 1'b1, 5, 2, 1'b0, 0, 12'h000, 1'b0, 12'h000);
    step(1'b1, 1'b1, 1'b0, 6, 2, 1'b0, 0, 12'h000, 1'b0, 12'h000);
    step(1'b1, 1'b1, 1'b1, H-1, V-1, 1'b0, 0, 12'h000, 1'b0, 12'h000);
    rand_visible(30);

    // five back-to-back writes while visible: queue fills, nothing drains
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b1, int'($urandom_range(0, H-1)), int'($urandom_range(0, V-1)),
           1'b1, int'($urandom_range(0, TOTAL-1)), 12'($urandom), 1'b0, 12'h000);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 0, 12'h000, 1'b0, 12'h000);

    // out-of-frame write is consumed without a RAM write
    step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1, TOTAL, 12'hABC, 1'b0, 12'h000);
    step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1, TOTAL + 5, 12'h123, 1'b0, 12'h000);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 0, 12'h000, 1'b0, 12'h000);

    // full-frame clear interleaved with visible lines and queued writes
    step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 0, 12'h000, 1'b1, 12'hF00);
    for (int i = 0; i < 6000 && m_active; i++) begin
      b  = ($urandom_range(0, 9) < 3);
      wv = ($urandom_range(0, 19) == 0);
      wa = int'($urandom_range(0, TOTAL-1));
      wd = 12'($urandom);
      cs = (i == 300);
      if (i == 50) begin
        b = 1'b0; wv = 1'b1; wa = 7; wd = 12'h0AB;
      end
      step(b, 1'($urandom), 1'b1,
           int'($urandom_range(0, H-1)), int'($urandom_range(0, V-1)),
           wv, wa, wd, cs, cs ? 12'h0FF : 12'($urandom));
    end
    check("clear_done_in_budget", 32'(clear_busy), 32'd0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 0, 12'h000, 1'b0, 12'h000);

    // read back the cleared frame
    step(1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 0, 12'h000, 1'b0, 12'h000);
    step(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 0, 12'h000, 1'b0, 12'h000);
    rand_visible(150);

    // reset mid-clear with two words queued
    step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 0, 12'h000, 1'b1, 12'h00F);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 0, 12'h000, 1'b0, 12'h000);
    step(1'b1, 1'b1, 1'b1, 3, 1, 1'b1, 11, 12'h5A5, 1'b0, 12'h000);
    step(1'b1, 1'b1, 1'b1, 4, 1, 1'b1, 12, 12'hA5A, 1'b0, 12'h000);
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 0, 12'h000, 1'b0, 12'h000);
    rand_visible(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
